// File: rtl/hack_fetch_unit_pkg.sv
// Shared definitions for the Hack fetch stage: widths, reset vector, FSM states
// and the {data,pc} payload carried through the output and skid registers.
package hack_fetch_unit_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/hack_fetch_unit_skid.sv
// One-entry skid buffer holding a fetched {data,pc} pair while decode stalls.
// Ports: clock/reset_n, load (capture din), unload (release entry), clear (flush),
//        din/dout entry payload, full (entry occupied).
// load wins over unload so a simultaneous drain-and-refill keeps the entry full.
module hack_fetch_unit_skid
  import hack_fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  // Entry register with flush priority over load/unload
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack CPU instruction fetch stage.
// Owns the program counter, drives the synchronous instruction ROM address and
// presents one instruction per cycle to decode over valid/ready.
// Ports: clock, reset_n (async active-low), jump/jump_addr (redirect from execute),
//        rom_addr/rom_data (1-cycle synchronous ROM), instr/instr_pc/instr_valid
//        (to decode), instr_ready (decode accepts).
module hack_fetch_unit
  import hack_fetch_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_addr,
  output logic [WORD_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  fetch_state_e      state, state_n;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_n;
  logic              inflight, inflight_n;
  fetch_entry_t      out_q, out_n;
  logic              valid_q, valid_n;
  fetch_entry_t      cap_entry, skid_dout;
  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic              skid_after, consume, out_free;

  // The word returning from ROM was issued last edge, so its address is fetch_pc-1
  assign cap_entry.data = rom_data;
  assign cap_entry.pc   = fetch_pc - WORD_W'(1);

  assign rom_addr    = fetch_pc;
  assign instr       = out_q.data;
  assign instr_pc    = out_q.pc;
  assign instr_valid = valid_q;

  hack_fetch_unit_skid u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .din     (cap_entry),
    .dout    (skid_dout),
    .full    (skid_full)
  );

  // State, PC, inflight flag and output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_VECTOR;
      inflight <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      inflight <= inflight_n;
      out_q    <= out_n;
      valid_q  <= valid_n;
    end
  end

  // Next-state: capture routing, skid drain, issue throttling, redirect
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    inflight_n  = 1'b0;
    out_n       = out_q;
    valid_n     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    consume     = valid_q & instr_ready;
    out_free    = ~valid_q | consume;
    skid_after  = skid_full;

    if (jump) begin
      // Any transfer this edge has already happened; everything younger is squashed
      fetch_pc_n = jump_addr;
      valid_n    = 1'b0;
      skid_clear = 1'b1;
      state_n    = ST_RUN;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          // Older skid entry goes first; a returning word takes its place
          out_n       = skid_dout;
          valid_n     = 1'b1;
          skid_unload = 1'b1;
          skid_after  = 1'b0;
          if (inflight) begin
            skid_load  = 1'b1;
            skid_after = 1'b1;
          end
        end else if (inflight) begin
          out_n   = cap_entry;
          valid_n = 1'b1;
        end else begin
          valid_n = 1'b0;
        end
      end else if (inflight) begin
        skid_load  = 1'b1;
        skid_after = 1'b1;
      end

      // Only issue when the word returning next edge is guaranteed a slot
      if (!skid_after) begin
        inflight_n = 1'b1;
        fetch_pc_n = fetch_pc + WORD_W'(1);
      end

      case (state)
        ST_BOOT: state_n = ST_RUN;
        default: state_n = (valid_q && !instr_ready) ? ST_HOLD : ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_fetch_unit.sv
module tb_hack_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic [15:0] mem [0:65535];

  int n_checks;
  int n_fail;

  // Reference model: queue of delivered-but-unconsumed words plus one outstanding fetch
  logic [15:0] q_pc[$];
  logic [15:0] q_data[$];
  logic        m_inflight;
  logic [15:0] m_inflight_pc;
  logic [15:0] m_pc;

  hack_fetch_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM
  always @(posedge clock) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_data.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = 16'h0000;
    m_pc          = 16'h0000;
  endtask

  // One rising edge of the model, using the inputs as they were before the edge
  task automatic model_step();
    if (!reset_n) return;
    if (q_pc.size() != 0 && instr_ready) begin
      void'(q_pc.pop_front());
      void'(q_data.pop_front());
    end
    if (m_inflight) begin
      q_pc.push_back(m_inflight_pc);
      q_data.push_back(mem[m_inflight_pc]);
    end
    if (jump) begin
      q_pc.delete();
      q_data.delete();
      m_inflight = 1'b0;
      m_pc       = jump_addr;
    end else if (q_pc.size() <= 1) begin
      m_inflight    = 1'b1;
      m_inflight_pc = m_pc;
      m_pc          = m_pc + 16'd1;
    end else begin
      m_inflight = 1'b0;
    end
  endtask

  task automatic compare();
    chk("rom_addr", rom_addr, m_pc);
    chk("instr_valid", 16'(instr_valid), 16'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      chk("instr", instr, q_data[0]);
      chk("instr_pc", instr_pc, q_pc[0]);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(16'h0100 + i);
    mem[16'hFFFF] = 16'hBEEF;

    reset_n     = 1'b0;
    jump        = 1'b0;
    jump_addr   = 16'h0000;
    instr_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_valid", 16'(instr_valid), 16'h0000);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_pc", instr_pc, 16'h0000);
    chk("reset_rom_addr", rom_addr, 16'h0000);

    // 1: latency and streaming
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    cycle();
    chk("t1_e0_valid", 16'(instr_valid), 16'h0000);
    cycle();
    chk("t1_e1_valid", 16'(instr_valid), 16'h0001);
    chk("t1_e1_pc", instr_pc, 16'h0000);
    chk("t1_e1_instr", instr, 16'h0100);
    cycle();
    chk("t1_e2_pc", instr_pc, 16'h0001);
    chk("t1_e2_instr", instr, 16'h0101);

    // 2: stall at pc 5
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && instr_pc == 16'h0005) found = 1'b1;
      else cycle();
    end
    chk("t2_reach_pc5", 16'(found), 16'h0001);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_instr", instr, 16'h0105);
      chk("t2_hold_pc", instr_pc, 16'h0005);
    end
    instr_ready = 1'b1;
    cycle();
    chk("t2_resume_pc6", instr_pc, 16'h0006);
    cycle();
    chk("t2_resume_pc7", instr_pc, 16'h0007);

    // 3: jump while streaming
    repeat (2) cycle();
    jump      = 1'b1;
    jump_addr = 16'h0040;
    cycle();
    jump = 1'b0;
    chk("t3_valid_drop", 16'(instr_valid), 16'h0000);
    chk("t3_rom_addr", rom_addr, 16'h0040);
    cycle();
    chk("t3_still_empty", 16'(instr_valid), 16'h0000);
    cycle();
    chk("t3_target_pc", instr_pc, 16'h0040);
    chk("t3_target_instr", instr, 16'h0140);

    // 4: fill skid, then jump
    instr_ready = 1'b0;
    repeat (4) cycle();
    jump      = 1'b1;
    jump_addr = 16'h0010;
    cycle();
    jump        = 1'b0;
    instr_ready = 1'b1;
    cycle();
    cycle();
    chk("t4_target_pc", instr_pc, 16'h0010);
    chk("t4_target_instr", instr, 16'h0110);

    // 5: wrap
    jump      = 1'b1;
    jump_addr = 16'hFFFF;
    cycle();
    jump = 1'b0;
    cycle();
    cycle();
    chk("t5_pc_ffff", instr_pc, 16'hFFFF);
    chk("t5_beef", instr, 16'hBEEF);
    cycle();
    chk("t5_wrap_pc", instr_pc, 16'h0000);
    chk("t5_wrap_instr", instr, 16'h0100);

    // 6: reset mid-stream between edges
    repeat (3) cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", 16'(instr_valid), 16'h0000);
    chk("t6_rom_addr", rom_addr, 16'h0000);
    compare();
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    cycle();
    chk("t6_restart_pc", instr_pc, 16'h0000);
    chk("t6_restart_instr", instr, 16'h0100);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
      end
      instr_ready = ($urandom_range(0, 9) < 7);
      jump        = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) jump_addr = 16'hFFFD + 16'($urandom_range(0, 2));
      else jump_addr = 16'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
